// File: rtl/gcd_req_driver.sv
// ---------------------------------------------------------------------------
// gcd_req_driver
//
// Traffic source and self-check for the GCD core. It generates pseudo-random
// operand pairs from a 32-bit Galois LFSR, issues them on the x/y/in_valid/
// in_ready request handshake, and captures each result on out/out_valid.
// Each result is sanity-checked: it must be nonzero and no larger than
// either operand. The block counts completed transactions, failed checks and
// spurious responses, and records the latency of the most recent response.
// A watchdog aborts the run if a request or a response stalls.
//
// Ports:
//   clock        sole clock, rising edge
//   reset        synchronous, active-low reset
//   start        one-cycle pulse, begins a run from IDLE or DONE
//   x, y         operands to the GCD core (held stable while in_valid=1)
//   in_valid     request valid
//   in_ready     core accepts the request
//   out          GCD result
//   out_valid    result valid for one cycle (no backpressure)
//   busy         core probe, informational only
//   done         run finished, held until the next start or reset
//   pass         valid when done=1: no errors and no timeout
//   timeout      sticky watchdog flag
//   txn_count    completed transactions
//   err_count    failed checks plus spurious responses (saturating)
//   last_latency cycles from handshake to the most recent response
// ---------------------------------------------------------------------------
module gcd_req_driver #(
  parameter int          WIDTH   = 32,
  parameter int          NUM_TXN = 16,
  parameter logic [31:0] SEED    = 32'h0000_0001,
  parameter int          TIMEOUT = 1024
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  output logic             in_valid,
  input  logic             in_ready,
  input  logic [WIDTH-1:0] out,
  input  logic             out_valid,
  input  logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [15:0]      txn_count,
  output logic [15:0]      err_count,
  output logic [15:0]      last_latency
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [31:0] TAP_MASK  = 32'h8020_0003;
  localparam logic [15:0] TXN_LIMIT = 16'(NUM_TXN);
  localparam logic [31:0] WD_LIMIT  = 32'(TIMEOUT - 1);

  state_t      state;
  logic [31:0] lfsr;
  logic [15:0] lat_count;
  logic [31:0] wd_count;

  logic [31:0] lfsr_s1;
  logic [31:0] lfsr_s2;
  logic [15:0] txn_next;
  logic [15:0] err_inc;
  logic [15:0] err_after_check;
  logic [15:0] lat_next;
  logic        resp_ok;
  logic        wd_expired;
  logic        busy_unused;

  // One Galois step, right shift; the tap mask folds in when bit 0 falls out.
  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? TAP_MASK : 32'h0);
  endfunction

  // A zero operand would make the GCD undefined, so it is bumped to 1.
  function automatic logic [WIDTH-1:0] to_operand(input logic [31:0] v);
    logic [WIDTH-1:0] o;
    o = v[WIDTH-1:0];
    return (o == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : o;
  endfunction

  // Two LFSR steps per pair: x comes from the first, y from the second.
  assign lfsr_s1 = lfsr_step(lfsr);
  assign lfsr_s2 = lfsr_step(lfsr_s1);

  assign txn_next        = txn_count + 16'd1;
  assign err_inc         = (err_count == 16'hFFFF) ? err_count : err_count + 16'd1;
  assign lat_next        = (lat_count == 16'hFFFF) ? lat_count : lat_count + 16'd1;
  assign resp_ok         = (out != '0) && (out <= x) && (out <= y);
  assign err_after_check = resp_ok ? err_count : err_inc;
  assign wd_expired      = (wd_count == WD_LIMIT);

  // The busy probe is only there for waveform visibility.
  assign busy_unused = busy;

  // Single control FSM. All outputs are registered here. A response in WAIT
  // is examined before the watchdog, so a result arriving on the last
  // allowed cycle still counts and the timeout is not raised.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= IDLE;
      lfsr         <= SEED;
      x            <= '0;
      y            <= '0;
      in_valid     <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      timeout      <= 1'b0;
      txn_count    <= 16'd0;
      err_count    <= 16'd0;
      last_latency <= 16'd0;
      lat_count    <= 16'd0;
      wd_count     <= 32'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          // The LFSR is not reseeded here, so successive runs see new pairs.
          if (start) begin
            txn_count <= 16'd0;
            err_count <= 16'd0;
            timeout   <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            x         <= to_operand(lfsr_s1);
            y         <= to_operand(lfsr_s2);
            lfsr      <= lfsr_s2;
            in_valid  <= 1'b1;
            wd_count  <= 32'd0;
            state     <= ISSUE;
          end
        end

        ISSUE: begin
          // A response while no request is outstanding is a protocol error.
          if (out_valid) begin
            err_count <= err_inc;
          end
          if (in_ready) begin
            in_valid  <= 1'b0;
            lat_count <= 16'd0;
            wd_count  <= 32'd0;
            state     <= WAIT;
          end else if (wd_expired) begin
            timeout  <= 1'b1;
            in_valid <= 1'b0;
            done     <= 1'b1;
            pass     <= 1'b0;
            state    <= DONE;
          end else begin
            wd_count <= wd_count + 32'd1;
          end
        end

        WAIT: begin
          if (out_valid) begin
            last_latency <= lat_next;
            txn_count    <= txn_next;
            err_count    <= err_after_check;
            if (txn_next == TXN_LIMIT) begin
              done  <= 1'b1;
              pass  <= (err_after_check == 16'd0) && !timeout;
              state <= DONE;
            end else begin
              x        <= to_operand(lfsr_s1);
              y        <= to_operand(lfsr_s2);
              lfsr     <= lfsr_s2;
              in_valid <= 1'b1;
              wd_count <= 32'd0;
              state    <= ISSUE;
            end
          end else if (wd_expired) begin
            timeout  <= 1'b1;
            in_valid <= 1'b0;
            done     <= 1'b1;
            pass     <= 1'b0;
            state    <= DONE;
          end else begin
            lat_count <= lat_next;
            wd_count  <= wd_count + 32'd1;
          end
        end

        default: begin
          in_valid <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_req_driver.sv
// ---------------------------------------------------------------------------
// tb_gcd_req_driver
//
// Directed bench for gcd_req_driver with NUM_TXN=4 and TIMEOUT=64. The bench
// plays the GCD core: it accepts requests, and answers with the true GCD or
// with deliberately wrong results. Inputs change on the falling edge and
// outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_gcd_req_driver;

  logic        clock;
  logic        reset;
  logic        start;
  logic [31:0] x;
  logic [31:0] y;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out;
  logic        out_valid;
  logic        busy;
  logic        done;
  logic        pass;
  logic        timeout;
  logic [15:0] txn_count;
  logic [15:0] err_count;
  logic [15:0] last_latency;

  int          n_checks;
  int          n_fail;
  logic [31:0] tb_lfsr;

  gcd_req_driver #(
    .WIDTH   (32),
    .NUM_TXN (4),
    .SEED    (32'h0000_0001),
    .TIMEOUT (64)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .x            (x),
    .y            (y),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out          (out),
    .out_valid    (out_valid),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .timeout      (timeout),
    .txn_count    (txn_count),
    .err_count    (err_count),
    .last_latency (last_latency)
  );

  // Free-running 10-unit clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Hard stop in case something wedges beyond the per-wait bounds.
  initial begin
    #200000;
    $display("[TB] FAIL global_time_limit: simulation did not finish");
    $fatal(1, "[TB] time limit");
  end

  function automatic logic [31:0] gcd(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Reference operand generator: two Galois steps per pair.
  task automatic next_pair(output logic [31:0] ex, output logic [31:0] ey);
    tb_lfsr = (tb_lfsr >> 1) ^ (tb_lfsr[0] ? 32'h8020_0003 : 32'h0);
    ex = (tb_lfsr == 0) ? 32'd1 : tb_lfsr;
    tb_lfsr = (tb_lfsr >> 1) ^ (tb_lfsr[0] ? 32'h8020_0003 : 32'h0);
    ey = (tb_lfsr == 0) ? 32'd1 : tb_lfsr;
  endtask

  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Core model for one transaction. mode 0: true GCD, 1: zero, 2: x+1,
  // 3: accept the request but never answer. Returns on a falling edge.
  task automatic serve_txn(input int ready_wait, input int resp_delay, input int mode,
                           output logic [31:0] xs, output logic [31:0] ys, output bit ok);
    int k;
    ok = 1'b1;
    xs = 32'h0;
    ys = 32'h0;
    k  = 0;
    while (in_valid !== 1'b1 && k < 200) begin
      @(negedge clock);
      k++;
    end
    if (in_valid !== 1'b1) begin
      ok = 1'b0;
      return;
    end
    xs = x;
    ys = y;
    repeat (ready_wait) @(negedge clock);
    in_ready = 1'b1;
    @(negedge clock);
    in_ready = 1'b0;
    if (mode == 3) return;
    repeat (resp_delay - 1) @(negedge clock);
    out_valid = 1'b1;
    case (mode)
      1:       out = 32'h0;
      2:       out = xs + 32'd1;
      default: out = gcd(xs, ys);
    endcase
    @(negedge clock);
    out_valid = 1'b0;
    out       = 32'h0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b1;
    repeat (3) @(negedge clock);
    n_checks++; if (x !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_x: got %h want 0", x); end
    n_checks++; if (y !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_y: got %h want 0", y); end
    n_checks++; if (in_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_in_valid: got %b want 0", in_valid); end
    n_checks++; if ({done, pass, timeout} !== 3'b000) begin n_fail++; $display("[TB] FAIL reset_flags: got %b want 000", {done, pass, timeout}); end
    n_checks++; if (txn_count !== 16'd0) begin n_fail++; $display("[TB] FAIL reset_txn: got %0d want 0", txn_count); end
    n_checks++; if (err_count !== 16'd0) begin n_fail++; $display("[TB] FAIL reset_err: got %0d want 0", err_count); end
    n_checks++; if (last_latency !== 16'd0) begin n_fail++; $display("[TB] FAIL reset_latency: got %0d want 0", last_latency); end
    reset = 1'b1;
    start = 1'b0;
    repeat (3) begin
      @(negedge clock);
      n_checks++; if (in_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_no_request: got %b want 0", in_valid); end
    end
    tb_lfsr = 32'h0000_0001;
  endtask

  task automatic test_basic();
    logic [31:0] xs, ys, ex, ey;
    bit ok;
    pulse_start();
    for (int t = 0; t < 4; t++) begin
      next_pair(ex, ey);
      serve_txn(0, 5, 0, xs, ys, ok);
      n_checks++; if (!ok) begin n_fail++; $display("[TB] FAIL basic_req_seen t%0d: got none want request", t); end
      if (t == 0) begin
        n_checks++; if (xs !== 32'h8020_0003) begin n_fail++; $display("[TB] FAIL basic_first_x: got %h want 80200003", xs); end
        n_checks++; if (ys !== 32'hC030_0002) begin n_fail++; $display("[TB] FAIL basic_first_y: got %h want c0300002", ys); end
      end
      n_checks++; if (xs !== ex || ys !== ey) begin n_fail++; $display("[TB] FAIL basic_pair t%0d: got %h/%h want %h/%h", t, xs, ys, ex, ey); end
    end
    n_checks++; if (txn_count !== 16'd4) begin n_fail++; $display("[TB] FAIL basic_txn: got %0d want 4", txn_count); end
    n_checks++; if (err_count !== 16'd0) begin n_fail++; $display("[TB] FAIL basic_err: got %0d want 0", err_count); end
    n_checks++; if (last_latency !== 16'd5) begin n_fail++; $display("[TB] FAIL basic_latency: got %0d want 5", last_latency); end
    n_checks++; if (done !== 1'b1 || pass !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_done_pass: got %b%b want 11", done, pass); end
    n_checks++; if (in_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_idle_after: got %b want 0", in_valid); end
  endtask

  task automatic test_backpressure();
    logic [31:0] xs, ys, ex, ey, x0, y0;
    bit ok;
    int k;
    bit stable;
    pulse_start();
    next_pair(ex, ey);
    k = 0;
    while (in_valid !== 1'b1 && k < 200) begin @(negedge clock); k++; end
    x0 = x;
    y0 = y;
    n_checks++; if (x0 !== ex || y0 !== ey) begin n_fail++; $display("[TB] FAIL bp_pair: got %h/%h want %h/%h", x0, y0, ex, ey); end
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (in_valid !== 1'b1 || x !== x0 || y !== y0) stable = 1'b0;
      @(negedge clock);
    end
    n_checks++; if (!stable) begin n_fail++; $display("[TB] FAIL bp_hold: got unstable want in_valid=1 and x/y held"); end
    in_ready = 1'b1;
    @(negedge clock);
    in_ready = 1'b0;
    n_checks++; if (in_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_handshake_drop: got %b want 0", in_valid); end
    stable = 1'b1;
    repeat (3) begin
      @(negedge clock);
      if (in_valid !== 1'b0) stable = 1'b0;
    end
    n_checks++; if (!stable) begin n_fail++; $display("[TB] FAIL bp_single_request: got reissue want none"); end
    out_valid = 1'b1;
    out       = gcd(x0, y0);
    @(negedge clock);
    out_valid = 1'b0;
    out       = 32'h0;
    for (int t = 1; t < 4; t++) begin
      next_pair(ex, ey);
      serve_txn(0, 2, 0, xs, ys, ok);
      n_checks++; if (!ok || xs !== ex || ys !== ey) begin n_fail++; $display("[TB] FAIL bp_pair t%0d: got %h/%h want %h/%h", t, xs, ys, ex, ey); end
    end
    n_checks++; if (last_latency !== 16'd2) begin n_fail++; $display("[TB] FAIL bp_latency: got %0d want 2", last_latency); end
    n_checks++; if (txn_count !== 16'd4 || err_count !== 16'd0 || pass !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_result: got txn=%0d err=%0d pass=%b want 4/0/1", txn_count, err_count, pass); end
  endtask

  task automatic test_bad_results();
    logic [31:0] xs, ys, ex, ey;
    bit ok;
    int modes [4];
    modes = '{0, 1, 2, 0};
    pulse_start();
    for (int t = 0; t < 4; t++) begin
      next_pair(ex, ey);
      serve_txn(1, 1, modes[t], xs, ys, ok);
      n_checks++; if (!ok || xs !== ex || ys !== ey) begin n_fail++; $display("[TB] FAIL bad_pair t%0d: got %h/%h want %h/%h", t, xs, ys, ex, ey); end
    end
    n_checks++; if (err_count !== 16'd2) begin n_fail++; $display("[TB] FAIL bad_err: got %0d want 2", err_count); end
    n_checks++; if (txn_count !== 16'd4) begin n_fail++; $display("[TB] FAIL bad_txn: got %0d want 4", txn_count); end
    n_checks++; if (done !== 1'b1 || pass !== 1'b0) begin n_fail++; $display("[TB] FAIL bad_done_pass: got %b%b want 10", done, pass); end
    n_checks++; if (last_latency !== 16'd1) begin n_fail++; $display("[TB] FAIL bad_latency: got %0d want 1", last_latency); end
  endtask

  task automatic test_timeout();
    logic [31:0] xs, ys, ex, ey;
    bit ok;
    int k;
    pulse_start();
    next_pair(ex, ey);
    serve_txn(0, 1, 3, xs, ys, ok);
    n_checks++; if (!ok || xs !== ex || ys !== ey) begin n_fail++; $display("[TB] FAIL to_pair: got %h/%h want %h/%h", xs, ys, ex, ey); end
    k = 0;
    while (timeout !== 1'b1 && k < 200) begin @(negedge clock); k++; end
    n_checks++; if (k !== 64) begin n_fail++; $display("[TB] FAIL to_cycles: got %0d want 64", k); end
    n_checks++; if (done !== 1'b1 || pass !== 1'b0 || in_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL to_flags: got done=%b pass=%b in_valid=%b want 1/0/0", done, pass, in_valid); end
    out_valid = 1'b1;
    out       = 32'd1;
    @(negedge clock);
    out_valid = 1'b0;
    out       = 32'h0;
    @(negedge clock);
    n_checks++; if (txn_count !== 16'd0 || err_count !== 16'd0) begin n_fail++; $display("[TB] FAIL to_late_resp: got txn=%0d err=%0d want 0/0", txn_count, err_count); end
    n_checks++; if (done !== 1'b1 || timeout !== 1'b1) begin n_fail++; $display("[TB] FAIL to_sticky: got done=%b timeout=%b want 1/1", done, timeout); end
  endtask

  task automatic test_mid_reset();
    logic [31:0] xs, ys, ex, ey;
    bit ok;
    pulse_start();
    for (int t = 0; t < 3; t++) begin
      next_pair(ex, ey);
      serve_txn(0, 3, (t == 2) ? 3 : 0, xs, ys, ok);
      n_checks++; if (!ok || xs !== ex || ys !== ey) begin n_fail++; $display("[TB] FAIL mr_pair t%0d: got %h/%h want %h/%h", t, xs, ys, ex, ey); end
    end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    n_checks++; if (in_valid !== 1'b0 || done !== 1'b0 || x !== 32'h0) begin n_fail++; $display("[TB] FAIL mr_idle: got in_valid=%b done=%b x=%h want 0/0/0", in_valid, done, x); end
    n_checks++; if (txn_count !== 16'd0 || err_count !== 16'd0 || last_latency !== 16'd0) begin n_fail++; $display("[TB] FAIL mr_counters: got %0d/%0d/%0d want 0/0/0", txn_count, err_count, last_latency); end
    out_valid = 1'b1;
    out       = 32'd7;
    @(negedge clock);
    out_valid = 1'b0;
    out       = 32'h0;
    @(negedge clock);
    n_checks++; if (txn_count !== 16'd0 || err_count !== 16'd0 || in_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL mr_stray_resp: got txn=%0d err=%0d in_valid=%b want 0/0/0", txn_count, err_count, in_valid); end
    tb_lfsr = 32'h0000_0001;
    pulse_start();
    for (int t = 0; t < 4; t++) begin
      next_pair(ex, ey);
      serve_txn(0, 2, 0, xs, ys, ok);
      if (t == 0) begin
        n_checks++; if (xs !== 32'h8020_0003 || ys !== 32'hC030_0002) begin n_fail++; $display("[TB] FAIL mr_reseed: got %h/%h want 80200003/c0300002", xs, ys); end
      end
      n_checks++; if (!ok || xs !== ex || ys !== ey) begin n_fail++; $display("[TB] FAIL mr_rerun_pair t%0d: got %h/%h want %h/%h", t, xs, ys, ex, ey); end
    end
    n_checks++; if (done !== 1'b1 || pass !== 1'b1 || txn_count !== 16'd4) begin n_fail++; $display("[TB] FAIL mr_rerun_result: got done=%b pass=%b txn=%0d want 1/1/4", done, pass, txn_count); end
  endtask

  // Scenarios run in sequence from one process.
  initial begin
    n_checks  = 0;
    n_fail    = 0;
    tb_lfsr   = 32'h0000_0001;
    reset     = 1'b0;
    start     = 1'b0;
    in_ready  = 1'b0;
    out       = 32'h0;
    out_valid = 1'b0;
    busy      = 1'b0;
    @(negedge clock);
    test_reset();
    test_basic();
    test_backpressure();
    test_bad_results();
    test_timeout();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gcd_req_driver.md
Name: gcd_req_driver

Overview:
- Synthesizable initiator for the GCD core's request/response protocol; the opposite end of the GCD responder.
- Generates pseudo-random operand pairs and issues them on the x/y/in_valid/in_ready handshake.
- Captures each result on out/out_valid and sanity-checks it.
- Counts transactions, errors and response latency. Used as an on-chip traffic source and self-check in the GCD test harness.

Parameters:
- WIDTH, 32: operand and result width.
- NUM_TXN, 16: transactions per run (1..65535).
- SEED, 32'h0000_0001: LFSR seed; must be nonzero.
- TIMEOUT, 1024: cycles allowed in ISSUE or WAIT before abort.

Ports:
- clock  input  1  sole clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- start  input  1  one-cycle pulse; begins a run from IDLE or DONE.
- x  output  WIDTH  operand A to the GCD core.
- y  output  WIDTH  operand B to the GCD core.
- in_valid  output  1  request valid.
- in_ready  input  1  core accepts the request.
- out  input  WIDTH  GCD result.
- out_valid  input  1  result valid for one cycle; no backpressure.
- busy  input  1  core probe; informational, not checked.
- done  output  1  run finished; held until the next start or reset.
- pass  output  1  valid when done=1: err_count==0 and no timeout.
- timeout  output  1  sticky watchdog flag.
- txn_count  output  16  completed transactions.
- err_count  output  16  failed checks plus spurious responses, saturating at 16'hFFFF.
- last_latency  output  16  latency of the most recent response.

Behaviour:
- Reset: sampled on the clock edge with reset==0. Clears state to IDLE and sets every output to 0 (x, y, in_valid, done, pass, timeout, all counters). Also reloads the LFSR with SEED. Reset applies from any state; a transaction in flight is abandoned.
- LFSR: 32-bit Galois, right shift, tap mask 32'h8020_0003. Each step: lfsr = (lfsr>>1) ^ (lfsr[0] ? mask : 0). Operands are taken as follows:
  - Each transaction steps twice: x is taken from step 1, y from step 2.
  - Each operand is the low WIDTH bits of the LFSR value; if that value is 0, the operand becomes 1.
  - With SEED=1, the first pair is x=32'h8020_0003, y=32'hC030_0002.
- IDLE: in_valid=0. On start: clear txn_count, err_count, timeout, done, pass; load the first pair; go to ISSUE.
- ISSUE: in_valid=1, and x/y are held stable until the handshake.
  - Handshake is in_valid & in_ready in the same cycle. On handshake: in_valid drops the next cycle, the latency counter is cleared, and the state goes to WAIT.
  - in_valid is never withdrawn without a handshake, except on reset or timeout.
- WAIT: in_valid=0; the latency counter increments every cycle, saturating. On out_valid:
  - Latch last_latency. A response one cycle after the handshake gives latency 1.
  - Check: out!=0, out<=x and out<=y. On failure, err_count+1.
  - txn_count+1.
  - If txn_count reaches NUM_TXN, go to DONE. Otherwise load the next pair and go to ISSUE on the next cycle.
- DONE: in_valid=0, done=1, pass=(err_count==0)&~timeout. A start pulse begins a new run; the LFSR continues and is not reseeded.
- Watchdog: a single counter, cleared on each entry to ISSUE or WAIT. Reaching TIMEOUT cycles sets timeout=1, in_valid=0 and forces DONE with pass=0.
- Spurious responses: out_valid in ISSUE gives err_count+1 and is otherwise ignored. out_valid in IDLE or DONE is ignored with no count.
- start outside IDLE/DONE is ignored.
- Simultaneous events:
  - out_valid and timeout in the same cycle: the response wins and the watchdog is not set.
  - start and reset==0 in the same cycle: reset wins.

Test Plan:
1. Reset: hold reset=0 for 3 cycles with start=1 -> all outputs 0, no in_valid afterwards.
2. Basic run: NUM_TXN=4, in_ready=1, bench model returns the true GCD 5 cycles after each handshake -> first request x=32'h8020_0003, y=32'hC030_0002; txn_count=4, err_count=0, last_latency=5, done=1, pass=1.
3. Backpressure: in_ready=0 for 10 cycles on transaction 0 -> in_valid=1 and x/y unchanged all 10 cycles; handshake on cycle 11; exactly one request issued.
4. Bad results: model returns out=0 on transaction 1 and out=x+1 on transaction 2 -> err_count=2, pass=0, txn_count=NUM_TXN.
5. Timeout: TIMEOUT=64, model never asserts out_valid -> timeout=1 and done=1 exactly 64 cycles after WAIT entry; pass=0; a late out_valid is ignored.
6. Mid-run reset: reset=0 for 1 cycle while in WAIT on transaction 2 -> next cycle IDLE, counters 0, in_valid=0; a later out_valid is not counted; a new start reissues x=32'h8020_0003.
